// File: rtl/count_sequencer.sv
// count_sequencer: start/pause/stop/reload run controller for a WIDTH-bit up-count.
// Define COUNT_PRESCALE_EN to add the presc_div port and tick prescaler.
module count_sequencer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  auto_reload,
  input  logic [WIDTH-1:0]      limit,
`ifdef COUNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef COUNT_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  presc_clr;
  logic                  presc_adv;

  assign tick      = (presc_q == presc_div);
  assign presc_clr = stop
                   | (start & ((state_q == S_IDLE)
                             | (state_q == S_DONE)));
  // Prescaler only runs while actually counting.
  assign presc_adv = (state_q == S_RUN) & ~pause;

  always_comb begin
    presc_d = presc_q;
    if (presc_clr) begin
      presc_d = '0;
    end else if (presc_adv) begin
      if (tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // PRESCALE_W only sizes the optional prescaler; every cycle ticks.
  assign tick = (PRESCALE_W != 0);
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_RUN;
            count_d  = '0;
            limit_d  = limit;
            reload_d = auto_reload;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_HOLD;
          end else if (tick) begin
            // Compare before increment so count never passes limit_q.
            if (count_q == limit_q) begin
              done_d = 1'b1;
              if (reload_q) begin
                count_d = '0;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        S_HOLD: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign state = state_q;
  assign busy  = (state_q == S_RUN)
               | (state_q == S_HOLD);

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed vector table, hand sequences,
// and random stimulus against a behavioural model.
module tb_count_sequencer;

  localparam int W  = 4;
  localparam int PW = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] limit = '0;
`ifdef COUNT_PRESCALE_EN
  logic [PW-1:0] presc_div = '0;
`endif
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .pause(pause),
    .auto_reload(auto_reload),
    .limit(limit),
`ifdef COUNT_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .count(count),
    .busy(busy),
    .done(done),
    .state(state)
  );

  typedef struct {
    logic         st, sp, pa, ar;
    logic [W-1:0] lim;
    logic [W-1:0] ec;
    logic [1:0]   es;
    logic         ed, eb;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  // behavioural model: run flags plus plain integer count
  bit m_armed, m_frozen, m_finished, m_periodic, m_done;
  int m_cnt, m_lim, m_pc;

  function automatic void model_reset();
    m_armed = 0; m_frozen = 0; m_finished = 0;
    m_periodic = 0; m_done = 0;
    m_cnt = 0; m_lim = 0; m_pc = 0;
  endfunction

  function automatic void model_step(bit st, bit sp, bit pa,
                                     bit ar, int lim, int div);
    bit t;
    m_done = 0;
    if (sp) begin
      m_armed = 0; m_frozen = 0; m_finished = 0;
      m_cnt = 0; m_pc = 0;
    end else if (m_armed) begin
      if (m_frozen) begin
        if (!pa) m_frozen = 0;
      end else if (pa) begin
        m_frozen = 1;
      end else begin
        t = (m_pc == div);
        m_pc = t ? 0 : (m_pc + 1) % (1 << PW);
        if (t) begin
          if (m_cnt == m_lim) begin
            m_done = 1;
            if (m_periodic) m_cnt = 0;
            else begin m_armed = 0; m_finished = 1; end
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
    end else if (st) begin
      m_armed = 1; m_finished = 0; m_cnt = 0;
      m_lim = lim; m_periodic = ar; m_pc = 0;
    end
  endfunction

  function automatic logic [1:0] model_state();
    if (m_finished) return 2'd3;
    if (!m_armed) return 2'd0;
    if (m_frozen) return 2'd2;
    return 2'd1;
  endfunction

  function automatic void addv(logic st, logic sp, logic pa, logic ar,
                               int lim, int ec, int es,
                               logic ed, logic eb);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.ar = ar;
    v.lim = W'(lim); v.ec = W'(ec); v.es = 2'(es);
    v.ed = ed; v.eb = eb;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [W-1:0] ec,
                       input logic [1:0] es, input logic ed,
                       input logic eb);
    n_vec++;
    if (count !== ec || state !== es || done !== ed || busy !== eb) begin
      n_bad++;
      $display("FAIL %s: got count=%0d state=%0d done=%0d busy=%0d, want count=%0d state=%0d done=%0d busy=%0d",
               name, count, state, done, busy, ec, es, ed, eb);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa,
                       input logic ar, input logic [W-1:0] lim);
    @(negedge clk);
    start = st; stop = sp; pause = pa;
    auto_reload = ar; limit = lim;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // one-shot, limit 3
    addv(1,0,0,0,3, 0,1,0,1);
    addv(0,0,0,0,0, 1,1,0,1);
    addv(0,0,0,0,0, 2,1,0,1);
    addv(0,0,0,0,0, 3,1,0,1);
    addv(0,0,0,0,0, 3,3,1,0);
    addv(0,0,0,0,0, 3,3,0,0);
    addv(0,0,0,0,0, 3,3,0,0);
    // auto-reload, limit 2, start from DONE
    addv(1,0,0,1,2, 0,1,0,1);
    addv(0,0,0,0,0, 1,1,0,1);
    addv(0,0,0,0,0, 2,1,0,1);
    addv(0,0,0,0,0, 0,1,1,1);
    addv(0,0,0,0,0, 1,1,0,1);
    addv(0,0,0,0,0, 2,1,0,1);
    addv(0,0,0,0,0, 0,1,1,1);
    addv(1,0,0,0,7, 1,1,0,1);
    addv(0,0,0,0,7, 2,1,0,1);
    addv(0,0,0,0,7, 0,1,1,1);
    // stop paths
    addv(0,1,0,0,0, 0,0,0,0);
    addv(1,0,0,0,7, 0,1,0,1);
    addv(0,0,0,0,0, 1,1,0,1);
    addv(0,0,0,0,0, 2,1,0,1);
    addv(0,0,0,0,0, 3,1,0,1);
    addv(0,0,0,0,0, 4,1,0,1);
    addv(0,1,0,0,0, 0,0,0,0);
    addv(1,1,0,0,5, 0,0,0,0);
    addv(0,0,0,0,0, 0,0,0,0);
    addv(1,0,0,0,1, 0,1,0,1);
    addv(0,0,0,0,0, 1,1,0,1);
    addv(0,1,0,0,0, 0,0,0,0);
    // limit 0
    addv(1,0,0,0,0, 0,1,0,1);
    addv(0,0,0,0,0, 0,3,1,0);
    addv(0,0,0,0,0, 0,3,0,0);
    // pause at count 2, limit 5
    addv(1,0,0,0,5, 0,1,0,1);
    addv(0,0,0,0,0, 1,1,0,1);
    addv(0,0,0,0,0, 2,1,0,1);
    addv(0,0,1,0,0, 2,2,0,1);
    addv(0,0,1,0,0, 2,2,0,1);
    addv(0,0,1,0,0, 2,2,0,1);
    addv(0,0,1,0,0, 2,2,0,1);
    addv(0,0,0,0,0, 2,1,0,1);
    addv(0,0,0,0,0, 3,1,0,1);
    addv(0,0,0,0,0, 4,1,0,1);
    addv(0,0,0,0,0, 5,1,0,1);
    addv(0,0,0,0,0, 5,3,1,0);
    // stop out of HOLD
    addv(1,0,0,0,3, 0,1,0,1);
    addv(0,0,1,0,0, 0,2,0,1);
    addv(0,1,1,0,0, 0,0,0,0);

    repeat (2) @(posedge clk);
    #1 check("reset_state", 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;

    // asynchronous reset mid-count
    drive(1,0,0,0,7);
    drive(0,0,0,0,7);
    drive(0,0,0,0,7);
    check("pre_reset_count2", 2, 1, 0, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;
    drive(0,0,0,0,0);
    check("idle_after_reset", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ar, tbl[i].lim);
      check($sformatf("tbl%0d", i), tbl[i].ec, tbl[i].es,
            tbl[i].ed, tbl[i].eb);
    end

    // count reaches all-ones limit without wrapping
    drive(1,0,0,0,15);
    for (int k = 1; k <= 15; k++) begin
      drive(0,0,0,0,0);
      check($sformatf("max_lim_c%0d", k), W'(k), 1, 0, 1);
    end
    drive(0,0,0,0,0);
    check("max_lim_done", 15, 3, 1, 0);

`ifdef COUNT_PRESCALE_EN
    @(negedge clk) presc_div = 2;
    drive(1,0,0,0,1);
    check("psc_start", 0, 1, 0, 1);
    drive(0,0,0,0,0);
    check("psc_e1", 0, 1, 0, 1);
    drive(0,0,0,0,0);
    check("psc_e2", 0, 1, 0, 1);
    drive(0,0,0,0,0);
    check("psc_e3", 1, 1, 0, 1);
    drive(0,0,0,0,0);
    check("psc_e4", 1, 1, 0, 1);
    drive(0,0,0,0,0);
    check("psc_e5", 1, 1, 0, 1);
    drive(0,0,0,0,0);
    check("psc_e6", 1, 3, 1, 0);
    @(negedge clk) presc_div = 0;
`endif

    // randomized run against the model
    @(negedge clk);
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    begin
      logic pa_lvl = 1'b0;
      int div = 0;
      for (int n = 0; n < 3000; n++) begin
        logic st, sp, ar;
        int lim;
        st = ($urandom_range(3) == 0);
        sp = ($urandom_range(24) == 0);
        ar = $urandom_range(1);
        if ($urandom_range(7) == 0) pa_lvl = ~pa_lvl;
        lim = $urandom_range(1) ? $urandom_range(3) : $urandom_range(15);
`ifdef COUNT_PRESCALE_EN
        if ($urandom_range(31) == 0) div = $urandom_range(3);
        presc_div = PW'(div);
`endif
        drive(st, sp, pa_lvl, ar, W'(lim));
        model_step(st, sp, pa_lvl, ar, lim, div);
        check($sformatf("rnd%0d", n), W'(m_cnt), model_state(),
              m_done, m_armed);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
